mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_addr_xlate.sv | 31 +++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_pkg
//  Purpose  : Shared CPU definitions used by the memory-port arbiter:
//             kseg0/kseg1 segment bounds and the channel-id width helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

   // Unmapped kernel segments kseg0 (cached) and kseg1 (uncached) together
   // span this contiguous range; both alias physical memory from address 0.
   localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
   localparam logic [31:0] KSEG1_END  = 32'hBFFF_FFFF;

   // Width of a channel index; never narrower than one bit so a
   // single-channel build still has a legal id field.
   function automatic int ch_id_width(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_addr_xlate.sv
`default_nettype none
// ============================================================================
//  Module   : addr_xlate
//  Purpose  : Virtual-to-physical translation for the unmapped kernel
//             segments. kseg0/kseg1 addresses lose bits [31:29]; all other
//             addresses pass through. MAP_EN=0 disables translation.
//  Ports    : vaddr [31:0] in  - virtual byte address
//             paddr [31:0] out - physical byte address
//  Revision : 1.0 - initial release
// ============================================================================
module addr_xlate
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAP_EN = 1
) (
   input  logic [31:0] vaddr,
   output logic [31:0] paddr
);

   if (MAP_EN != 0) begin : g_map
      logic in_kseg01;
      always_comb begin
         in_kseg01 = (vaddr >= KSEG0_BASE) && (vaddr <= KSEG1_END);
         paddr     = in_kseg01 ? {3'b000, vaddr[28:0]} : vaddr;
      end
   end else begin : g_pass
      assign paddr = vaddr;
   end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Round-robin arbiter sharing one SRAM port among NCH channels,
//             with fixed-latency read return routed back to the requester.
//  Ports    : clk, rst (async, active-high)
//             stall_i              in  - suppress grants this cycle
//             ch_req/wen/addr/wdata in - per-channel request bundle
//             ch_gnt               out - one-hot grant (combinational)
//             ch_rvalid, ch_rdata  out - read return, one-hot strobe + data
//             sram_en/wen/addr/wdata out, sram_rdata in - SRAM port
//             busy                 out - a read is in flight
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int NCH    = 2,
   parameter int LAT    = 1,
   parameter int MAP_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic [NCH-1:0]    ch_req,
   input  logic [4*NCH-1:0]  ch_wen,
   input  logic [32*NCH-1:0] ch_addr,
   input  logic [32*NCH-1:0] ch_wdata,
   output logic [NCH-1:0]    ch_gnt,
   output logic [NCH-1:0]    ch_rvalid,
   output logic [31:0]       ch_rdata,
   output logic              sram_en,
   output logic [3:0]        sram_wen,
   output logic [31:0]       sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata,
   output logic              busy
);

   localparam int IDW = ch_id_width(NCH);

   logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [LAT-1:0]          pipe_vld_q, pipe_vld_d;
   logic [LAT-1:0][IDW-1:0] pipe_id_q, pipe_id_d;

   logic                    gnt_vld;
   logic [IDW-1:0]          gnt_id;
   logic [3:0]              gnt_wen;
   logic [31:0]             gnt_vaddr;
   int                      scan_idx;

   // Round-robin scan starting at rr_ptr; the first asserted request wins.
   // Reset is folded in so no grant is visible while rst is held.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_id   = '0;
      scan_idx = 0;
      for (int i = 0; i < NCH; i++) begin
         scan_idx = (int'(rr_ptr_q) + i) % NCH;
         if (!gnt_vld && ch_req[scan_idx]) begin
            gnt_vld = 1'b1;
            gnt_id  = IDW'(scan_idx);
         end
      end
      if (stall_i || rst) begin
         gnt_vld = 1'b0;
      end
   end

   always_comb begin
      ch_gnt = '0;
      for (int i = 0; i < NCH; i++) begin
         ch_gnt[i] = gnt_vld && (gnt_id == IDW'(i));
      end
      gnt_wen    = ch_wen[int'(gnt_id)*4 +: 4];
      gnt_vaddr  = ch_addr[int'(gnt_id)*32 +: 32];
      sram_en    = gnt_vld;
      sram_wen   = gnt_vld ? gnt_wen : 4'h0;
      sram_wdata = gnt_vld ? ch_wdata[int'(gnt_id)*32 +: 32] : 32'h0;
   end

   addr_xlate #(
      .MAP_EN (MAP_EN)
   ) u_addr_xlate (
      .vaddr (gnt_vaddr),
      .paddr (sram_addr)
   );

   // Next-state: pointer advances past the winner; the return pipeline
   // shifts every cycle regardless of stall so in-flight reads keep timing.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_vld) begin
         rr_ptr_d = IDW'((int'(gnt_id) + 1) % NCH);
      end
      pipe_vld_d    = '0;
      pipe_id_d     = '0;
      pipe_vld_d[0] = gnt_vld && (gnt_wen == 4'h0);
      pipe_id_d[0]  = gnt_id;
      for (int s = 1; s < LAT; s++) begin
         pipe_vld_d[s] = pipe_vld_q[s-1];
         pipe_id_d[s]  = pipe_id_q[s-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         pipe_vld_q <= '0;
         pipe_id_q  <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         pipe_vld_q <= pipe_vld_d;
         pipe_id_q  <= pipe_id_d;
      end
   end

   // The last pipeline stage lines up with the SRAM's read data.
   always_comb begin
      ch_rvalid = '0;
      for (int i = 0; i < NCH; i++) begin
         ch_rvalid[i] = pipe_vld_q[LAT-1] && (pipe_id_q[LAT-1] == IDW'(i));
      end
      ch_rdata = pipe_vld_q[LAT-1] ? sram_rdata : 32'h0;
      busy     = |pipe_vld_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter. Three instances:
//             A (NCH=2, LAT=1, MAP_EN=1), B (NCH=4, LAT=3, MAP_EN=1),
//             C (NCH=2, LAT=2, MAP_EN=0). Read returns are predicted into
//             a scoreboard at grant time and checked when they come due.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- instance A ----------------
   logic        a_stall = 1'b0;
   logic [1:0]  a_req = 2'b00;
   logic [7:0]  a_wen = 8'h0;
   logic [63:0] a_addr = 64'h0, a_wdata = 64'h0;
   logic [1:0]  a_gnt, a_rvalid;
   logic [31:0] a_rdata, a_saddr, a_swdata, a_srd;
   logic        a_en, a_busy;
   logic [3:0]  a_swen;

   // ---------------- instance B ----------------
   logic         b_stall = 1'b0;
   logic [3:0]   b_req = 4'h0;
   logic [15:0]  b_wen = 16'h0;
   logic [127:0] b_addr = 128'h0, b_wdata = 128'h0;
   logic [3:0]   b_gnt, b_rvalid;
   logic [31:0]  b_rdata, b_saddr, b_swdata, b_srd;
   logic         b_en, b_busy;
   logic [3:0]   b_swen;

   // ---------------- instance C ----------------
   logic        c_stall = 1'b0;
   logic [1:0]  c_req = 2'b00;
   logic [7:0]  c_wen = 8'h0;
   logic [63:0] c_addr = 64'h0, c_wdata = 64'h0;
   logic [1:0]  c_gnt, c_rvalid;
   logic [31:0] c_rdata, c_saddr, c_swdata, c_srd;
   logic        c_en, c_busy;
   logic [3:0]  c_swen;

   int beef_cyc = -1;

   // SRAM models: read data is a per-instance tag plus the current cycle.
   assign a_srd = {16'hA000, 16'(cyc)};
   assign b_srd = (cyc == beef_cyc) ? 32'hDEAD_BEEF : {16'hB000, 16'(cyc)};
   assign c_srd = {16'hC000, 16'(cyc)};

   mem_port_arbiter #(.NCH(2), .LAT(1), .MAP_EN(1)) u_dut_a (
      .clk(clk), .rst(rst), .stall_i(a_stall), .ch_req(a_req), .ch_wen(a_wen),
      .ch_addr(a_addr), .ch_wdata(a_wdata), .ch_gnt(a_gnt), .ch_rvalid(a_rvalid),
      .ch_rdata(a_rdata), .sram_en(a_en), .sram_wen(a_swen), .sram_addr(a_saddr),
      .sram_wdata(a_swdata), .sram_rdata(a_srd), .busy(a_busy));

   mem_port_arbiter #(.NCH(4), .LAT(3), .MAP_EN(1)) u_dut_b (
      .clk(clk), .rst(rst), .stall_i(b_stall), .ch_req(b_req), .ch_wen(b_wen),
      .ch_addr(b_addr), .ch_wdata(b_wdata), .ch_gnt(b_gnt), .ch_rvalid(b_rvalid),
      .ch_rdata(b_rdata), .sram_en(b_en), .sram_wen(b_swen), .sram_addr(b_saddr),
      .sram_wdata(b_swdata), .sram_rdata(b_srd), .busy(b_busy));

   mem_port_arbiter #(.NCH(2), .LAT(2), .MAP_EN(0)) u_dut_c (
      .clk(clk), .rst(rst), .stall_i(c_stall), .ch_req(c_req), .ch_wen(c_wen),
      .ch_addr(c_addr), .ch_wdata(c_wdata), .ch_gnt(c_gnt), .ch_rvalid(c_rvalid),
      .ch_rdata(c_rdata), .sram_en(c_en), .sram_wen(c_swen), .sram_addr(c_saddr),
      .sram_wdata(c_swdata), .sram_rdata(c_srd), .busy(c_busy));

   // ---------------- scoreboard ----------------
   typedef struct {
      int         dut;
      int         due;
      logic [3:0] rvalid;
      logic [31:0] rdata;
   } sb_t;

   sb_t sb_q[$];
   int  n_vec  = 0;
   int  n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] exp_rd(input int d, input int due);
      case (d)
         0:       return {16'hA000, 16'(due)};
         1:       return {16'hB000, 16'(due)};
         default: return {16'hC000, 16'(due)};
      endcase
   endfunction

   task automatic push(input int d, input int due, input logic [3:0] rv, input logic [31:0] rd);
      sb_t e;
      e.dut    = d;
      e.due    = due;
      e.rvalid = rv;
      e.rdata  = rd;
      sb_q.push_back(e);
   endtask

   task automatic mon(input int d, input logic [3:0] rv, input logic [31:0] rd);
      bit hit;
      hit = 1'b0;
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].dut == d && sb_q[i].due < cyc) begin
            n_vec++;
            n_fail++;
            $display("FAIL late_rvalid dut%0d: entry due at %0d never matched (now %0d)",
                     d, sb_q[i].due, cyc);
            sb_q.delete(i);
         end
      end
      for (int i = 0; i < sb_q.size(); i++) begin
         if (!hit && sb_q[i].dut == d && sb_q[i].due == cyc) begin
            chk($sformatf("dut%0d_rvalid", d), 32'(rv), 32'(sb_q[i].rvalid));
            chk($sformatf("dut%0d_rdata", d), rd, sb_q[i].rdata);
            sb_q.delete(i);
            hit = 1'b1;
         end
      end
      if (!hit) begin
         chk($sformatf("dut%0d_idle_rvalid", d), 32'(rv), 32'h0);
         chk($sformatf("dut%0d_idle_rdata", d), rd, 32'h0);
      end
   endtask

   // One clock: return checks on the falling edge, then resume just past
   // the next rising edge where the caller drives fresh inputs.
   task automatic step();
      @(negedge clk);
      mon(0, {2'b00, a_rvalid}, a_rdata);
      mon(1, b_rvalid, b_rdata);
      mon(2, {2'b00, c_rvalid}, c_rdata);
      @(posedge clk);
      #1;
   endtask

   // ---------------- vector table for instance A ----------------
   typedef struct {
      logic        stall;
      logic [1:0]  req;
      logic [3:0]  wen0;
      logic [3:0]  wen1;
      logic [31:0] addr0;
      logic [31:0] addr1;
      logic [1:0]  egnt;
      logic [3:0]  ewen;
      logic [31:0] eaddr;
   } vec_t;

   localparam int NV = 13;
   vec_t tbl[NV];

   initial begin
      //           stall req    wen0  wen1  addr0         addr1         egnt   ewen  eaddr
      tbl[0]  = '{1'b0, 2'b11, 4'h0, 4'h0, 32'h8000_0010, 32'hBFC0_0000, 2'b01, 4'h0, 32'h0000_0010};
      tbl[1]  = '{1'b0, 2'b10, 4'h0, 4'h0, 32'h8000_0010, 32'hBFC0_0000, 2'b10, 4'h0, 32'h1FC0_0000};
      tbl[2]  = '{1'b0, 2'b01, 4'hF, 4'h0, 32'h0000_1000, 32'h0000_0000, 2'b01, 4'hF, 32'h0000_1000};
      tbl[3]  = '{1'b0, 2'b00, 4'h0, 4'h0, 32'h0000_0000, 32'h0000_0000, 2'b00, 4'h0, 32'h0000_0000};
      tbl[4]  = '{1'b0, 2'b11, 4'h0, 4'h0, 32'hC000_0004, 32'h7FFF_FFFC, 2'b10, 4'h0, 32'h7FFF_FFFC};
      tbl[5]  = '{1'b1, 2'b11, 4'h0, 4'h0, 32'hC000_0004, 32'hA000_0000, 2'b00, 4'h0, 32'h0000_0000};
      tbl[6]  = '{1'b0, 2'b11, 4'h0, 4'h0, 32'hC000_0004, 32'hA000_0000, 2'b01, 4'h0, 32'hC000_0004};
      tbl[7]  = '{1'b0, 2'b11, 4'h0, 4'h0, 32'hC000_0004, 32'hA000_0000, 2'b10, 4'h0, 32'h0000_0000};
      tbl[8]  = '{1'b0, 2'b11, 4'h0, 4'h0, 32'hBFFF_FFFF, 32'h8000_0000, 2'b01, 4'h0, 32'h1FFF_FFFF};
      tbl[9]  = '{1'b0, 2'b11, 4'h0, 4'h0, 32'hBFFF_FFFF, 32'h8000_0000, 2'b10, 4'h0, 32'h0000_0000};
      tbl[10] = '{1'b0, 2'b01, 4'h3, 4'h0, 32'h8000_0100, 32'h0000_0000, 2'b01, 4'h3, 32'h0000_0100};
      tbl[11] = '{1'b0, 2'b01, 4'h0, 4'h0, 32'h0000_0020, 32'h0000_0000, 2'b01, 4'h0, 32'h0000_0020};
      tbl[12] = '{1'b0, 2'b11, 4'h0, 4'hC, 32'h0000_0020, 32'hDFFF_FFFC, 2'b10, 4'hC, 32'hDFFF_FFFC};

      // ---- reset: requests held on A must not produce a grant ----
      rst   = 1'b1;
      a_req = 2'b11;
      step();
      chk("rst_a_gnt", 32'(a_gnt), 32'h0);
      chk("rst_a_en_wen", 32'({a_en, a_swen}), 32'h0);
      chk("rst_busy_all", 32'({a_busy, b_busy, c_busy}), 32'h0);
      chk("rst_rvalid_all", 32'({a_rvalid, b_rvalid, c_rvalid}), 32'h0);
      rst   = 1'b0;
      a_req = 2'b00;
      step();

      // ---- instance A: table-driven grant / translation vectors ----
      for (int i = 0; i < NV; i++) begin
         a_stall = tbl[i].stall;
         a_req   = tbl[i].req;
         a_wen   = {tbl[i].wen1, tbl[i].wen0};
         a_addr  = {tbl[i].addr1, tbl[i].addr0};
         a_wdata = {32'h2222_0000 + 32'(i), 32'h1111_0000 + 32'(i)};
         #1;
         chk($sformatf("v%0d_gnt", i), 32'(a_gnt), 32'(tbl[i].egnt));
         chk($sformatf("v%0d_en", i), 32'(a_en), 32'(tbl[i].egnt != 2'b00));
         chk($sformatf("v%0d_wen", i), 32'(a_swen), 32'(tbl[i].ewen));
         if (tbl[i].egnt != 2'b00) begin
            chk($sformatf("v%0d_addr", i), a_saddr, tbl[i].eaddr);
            chk($sformatf("v%0d_wdata", i), a_swdata,
                tbl[i].egnt[0] ? 32'h1111_0000 + 32'(i) : 32'h2222_0000 + 32'(i));
            if (tbl[i].ewen == 4'h0)
               push(0, cyc + 1, {2'b00, tbl[i].egnt}, exp_rd(0, cyc + 1));
         end
         step();
      end
      a_req   = 2'b00;
      a_stall = 1'b0;
      a_wen   = 8'h0;
      step();
      step();

      // ---- instance B: four held requests rotate 0,1,2,3,0,1,2,3 ----
      b_addr = {32'h8000_0300, 32'h8000_0200, 32'hA000_0100, 32'h0000_0000};
      b_req  = 4'hF;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk($sformatf("rr%0d_gnt", k), 32'(b_gnt), 32'(4'b0001 << (k % 4)));
         chk($sformatf("rr%0d_addr", k), b_saddr, 32'(k % 4) << 8);
         push(1, cyc + 3, 4'b0001 << (k % 4), exp_rd(1, cyc + 3));
         step();
      end
      b_req = 4'h0;
      for (int k = 0; k < 4; k++) step();
      chk("b_busy_drained", 32'(b_busy), 32'h0);

      // ---- instance B: single read returns exactly LAT=3 cycles later ----
      b_req = 4'b0010;
      #1;
      chk("lat3_gnt", 32'(b_gnt), 32'h2);
      beef_cyc = cyc + 3;
      push(1, cyc + 3, 4'b0010, 32'hDEAD_BEEF);
      step();
      b_req = 4'h0;
      chk("lat3_busy", 32'(b_busy), 32'h1);
      for (int k = 0; k < 4; k++) step();

      // ---- instance B: stall with a read in flight ----
      b_req = 4'b0100;
      #1;
      chk("stall_pre_gnt", 32'(b_gnt), 32'h4);
      push(1, cyc + 3, 4'b0100, exp_rd(1, cyc + 3));
      step();
      b_stall = 1'b1;
      b_req   = 4'hF;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk($sformatf("stall%0d_gnt", k), 32'(b_gnt), 32'h0);
         chk($sformatf("stall%0d_en", k), 32'({b_en, b_swen}), 32'h0);
         step();
      end
      b_stall = 1'b0;
      #1;
      chk("stall_post_gnt", 32'(b_gnt), 32'h8);
      push(1, cyc + 3, 4'b1000, exp_rd(1, cyc + 3));
      step();
      b_req = 4'h0;
      for (int k = 0; k < 4; k++) step();

      // ---- instance C: pass-through addressing ----
      c_addr = {32'h0000_0000, 32'h9000_0000};
      c_req  = 2'b01;
      #1;
      chk("nomap_gnt", 32'(c_gnt), 32'h1);
      chk("nomap_addr", c_saddr, 32'h9000_0000);
      push(2, cyc + 2, 4'b0001, exp_rd(2, cyc + 2));
      step();
      c_req = 2'b00;
      step();
      step();

      // ---- instance C: reset one cycle after a read grant ----
      c_addr = {32'h0000_0080, 32'h0000_0040};
      c_req  = 2'b01;
      #1;
      chk("rstfly_gnt", 32'(c_gnt), 32'h1);
      step();
      c_req = 2'b00;
      #1;
      chk("rstfly_busy_pre", 32'(c_busy), 32'h1);
      rst = 1'b1;
      #1;
      chk("rstfly_busy", 32'(c_busy), 32'h0);
      chk("rstfly_rvalid", 32'(c_rvalid), 32'h0);
      step();
      rst = 1'b0;
      step();
      step();
      c_req = 2'b11;
      #1;
      chk("rstfly_next_gnt", 32'(c_gnt), 32'h1);
      push(2, cyc + 2, 4'b0001, exp_rd(2, cyc + 2));
      step();
      c_req = 2'b00;
      for (int k = 0; k < 4; k++) step();

      chk("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
